// File: rtl/cpa_rr_arbiter.sv
// cpa_rr_arbiter: round-robin arbiter sharing one 16-bit prefix CPA among
// NREQ requesters. The result lands in a one-entry registered output stage.

// mg_cpa: Kogge-Stone prefix carry-propagate adder, no carry-in.
module mg_cpa #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Log-depth generate/propagate prefix tree, then sum = p ^ carry-in-per-bit
  always_comb begin : prefix
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g_nx;
    logic [WIDTH-1:0] p_nx;
    logic [WIDTH-1:0] p0;
    g  = a & b;
    p  = a ^ b;
    p0 = p;
    for (int unsigned d = 1; d < WIDTH; d = d * 2) begin
      g_nx = g;
      p_nx = p;
      for (int unsigned i = d; i < WIDTH; i++) begin
        g_nx[i] = g[i] | (p[i] & g[i-d]);
        p_nx[i] = p[i] & p[i-d];
      end
      g = g_nx;
      p = p_nx;
    end
    sum  = p0 ^ {g[WIDTH-2:0], 1'b0};
    cout = g[WIDTH-1];
  end

endmodule

module cpa_rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_sum,
  output logic                  out_cout,
  output logic [IDW-1:0]        out_id
);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic [IDW-1:0]   out_id_q, out_id_d;

  logic             found;
  logic             accept;
  logic             grant;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] cpa_sum;
  logic             cpa_cout;

  // Rotating priority search from ptr; selects the winner's operands for the CPA.
  // Nested loops keep every index a loop constant so the mux stays purely static.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && (i == (32'(ptr_q) + k) % NREQ) && req_valid[i]) begin
          found   = 1'b1;
          gnt_idx = IDW'(i);
          sel_a   = req_a[i*WIDTH +: WIDTH];
          sel_b   = req_b[i*WIDTH +: WIDTH];
        end
      end
    end
    accept = !out_valid_q || out_ready;
    grant  = found && accept && !rst;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = grant && (gnt_idx == IDW'(i));
    end
  end

  mg_cpa #(.WIDTH(WIDTH)) u_mg_cpa (
    .a    (sel_a),
    .b    (sel_b),
    .sum  (cpa_sum),
    .cout (cpa_cout)
  );

  // Next-state for pointer and output stage: load on grant, empty on drain-only.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_id_d    = out_id_q;
    if (grant) begin
      ptr_d       = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      out_valid_d = 1'b1;
      out_sum_d   = cpa_sum;
      out_cout_d  = cpa_cout;
      out_id_d    = gnt_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_cpa_rr_arbiter.sv
// Self-checking bench for cpa_rr_arbiter: reference round-robin model plus
// an expected-result queue filled at grant time and drained at output time.
module tb_cpa_rr_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           cout;
    logic [W-1:0]   sum;
  } exp_t;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_sum;
  logic                out_cout;
  logic [IDW-1:0]      out_id;

  exp_t        sbq[$];
  exp_t        last_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned m_ptr    = 0;
  bit          m_ov     = 0;

  cpa_rr_arbiter #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_id    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  // Reference grant choice for the current inputs, -1 when nothing is granted.
  function automatic int model_pick(input logic [NREQ-1:0] v);
    if (rst || (m_ov && !out_ready)) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx = (int'(m_ptr) + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic exp_t model_result(input int g);
    logic [W:0] s;
    s = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]};
    return exp_t'({2'(g), s});
  endfunction

  // One clock: predict grant, queue its result, advance the model, settle.
  task automatic step(output int g_out);
    int g;
    g = model_pick(req_valid);
    if (g >= 0) sbq.push_back(model_result(g));
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_ov = 0; sbq.delete(); last_e = '0;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % NREQ; m_ov = 1;
    end else if (out_ready) begin
      m_ov = 0;
    end
    #1;
    g_out = g;
  endtask

  task automatic do_reset();
    int g;
    rst = 1'b1; req_valid = '0;
    step(g);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int g;
    rst = 1'b1; req_valid = 4'hF; out_ready = 1'b1;
    req_a = {4{16'h1234}}; req_b = {4{16'h0101}};
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    step(g);
    n_checks++;
    if ({out_valid, out_id, out_cout, out_sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b id=%0d c=%b s=%h want all zero", out_valid, out_id, out_cout, out_sum);
    end
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_single_add();
    int g; exp_t e;
    req_valid = 4'b0001; req_a[15:0] = 16'hFFFF; req_b[15:0] = 16'h0001; out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    step(g);
    req_valid = '0;
    e = sbq.pop_front(); last_e = e;
    n_checks++;
    if ({out_valid, out_id, out_cout, out_sum} !== {1'b1, 2'd0, 1'b1, 16'h0000} || e !== {out_id, out_cout, out_sum}) begin
      n_fail++;
      $display("FAIL single_result: got v=%b id=%0d c=%b s=%h want v=1 id=0 c=1 s=0000", out_valid, out_id, out_cout, out_sum);
    end
    step(g);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_all_valid();
    int g; exp_t e;
    int exp_ids[5] = '{0, 1, 2, 3, 0};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = 16'(i * 16'h1111);
      req_b[i*W +: W] = 16'h0100;
    end
    req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (req_ready !== 4'(1 << exp_ids[c])) begin
        n_fail++; $display("FAIL all_ready[%0d]: got %b want %b", c, req_ready, 4'(1 << exp_ids[c]));
      end
      step(g);
      e = sbq.pop_front(); last_e = e;
      n_checks++;
      if (out_valid !== 1'b1 || {out_id, out_cout, out_sum} !== e || out_id !== 2'(exp_ids[c])) begin
        n_fail++;
        $display("FAIL all_result[%0d]: got v=%b id=%0d c=%b s=%h want v=1 id=%0d c=%b s=%h", c, out_valid, out_id, out_cout, out_sum, exp_ids[c], e.cout, e.sum);
      end
      if (exp_ids[c] == 2) begin
        n_checks++;
        if ({out_cout, out_sum} !== {1'b0, 16'h2322}) begin
          n_fail++; $display("FAIL all_id2_sum: got c=%b s=%h want c=0 s=2322", out_cout, out_sum);
        end
      end
    end
    req_valid = '0;
    step(g);
  endtask

  task automatic test_backpressure();
    int g; exp_t e; exp_t held;
    req_valid = 4'b1010; out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_first_ready: got %b want 0010", req_ready);
    end
    step(g);
    req_valid = 4'b1000;
    e = sbq.pop_front(); held = e; last_e = e;
    n_checks++;
    if (out_valid !== 1'b1 || {out_id, out_cout, out_sum} !== e) begin
      n_fail++; $display("FAIL bp_first_result: got v=%b id=%0d s=%h want v=1 id=%0d s=%h", out_valid, out_id, out_sum, e.id, e.sum);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b want 0000", k, req_ready);
      end
      step(g);
      n_checks++;
      if ({out_valid, out_id, out_cout, out_sum} !== {1'b1, held}) begin
        n_fail++; $display("FAIL bp_frozen[%0d]: got v=%b id=%0d s=%h want v=1 id=%0d s=%h", k, out_valid, out_id, out_sum, held.id, held.sum);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL bp_release_ready: got %b want 1000", req_ready);
    end
    step(g);
    req_valid = '0;
    e = sbq.pop_front(); last_e = e;
    n_checks++;
    if (out_valid !== 1'b1 || {out_id, out_cout, out_sum} !== e || out_id !== 2'd3) begin
      n_fail++; $display("FAIL bp_release_result: got v=%b id=%0d s=%h want v=1 id=3 s=%h", out_valid, out_id, out_sum, e.sum);
    end
    step(g);
  endtask

  task automatic test_wrap_skip();
    int g; exp_t e;
    do_reset();
    out_ready = 1'b1; req_valid = 4'b0100;
    #1;
    step(g);
    req_valid = 4'b0010;
    void'(sbq.pop_front());
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL wrap_ready: got %b want 0010", req_ready);
    end
    step(g);
    e = sbq.pop_front(); last_e = e;
    n_checks++;
    if (out_valid !== 1'b1 || {out_id, out_cout, out_sum} !== e || out_id !== 2'd1) begin
      n_fail++; $display("FAIL wrap_result: got v=%b id=%0d s=%h want v=1 id=1 s=%h", out_valid, out_id, out_sum, e.sum);
    end
    req_a[16 +: 16] = 16'h1234; req_b[16 +: 16] = 16'h4321;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL skip_ready: got %b want 0010", req_ready);
    end
    step(g);
    req_valid = '0;
    e = sbq.pop_front(); last_e = e;
    n_checks++;
    if (out_valid !== 1'b1 || {out_id, out_cout, out_sum} !== {2'd1, 1'b0, 16'h5555} || {out_id, out_cout, out_sum} !== e) begin
      n_fail++; $display("FAIL skip_result: got v=%b id=%0d c=%b s=%h want v=1 id=1 c=0 s=5555", out_valid, out_id, out_cout, out_sum);
    end
    step(g);
  endtask

  task automatic test_reset_mid();
    int g; exp_t e;
    do_reset();
    out_ready = 1'b0; req_valid = 4'b0100;
    #1;
    step(g);
    req_valid = 4'b0101;
    e = sbq.pop_front(); last_e = e;
    n_checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd2 || {out_id, out_cout, out_sum} !== e) begin
      n_fail++; $display("FAIL rmid_load: got v=%b id=%0d want v=1 id=2", out_valid, out_id);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rmid_ready_in_reset: got %b want 0000", req_ready);
    end
    step(g);
    rst = 1'b0;
    n_checks++;
    if ({out_valid, out_id, out_cout, out_sum} !== '0) begin
      n_fail++; $display("FAIL rmid_cleared: got v=%b id=%0d s=%h want all zero", out_valid, out_id, out_sum);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rmid_first_grant: got %b want 0001", req_ready);
    end
    step(g);
    req_valid = 4'b0100;
    e = sbq.pop_front(); last_e = e;
    n_checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd0 || {out_id, out_cout, out_sum} !== e) begin
      n_fail++; $display("FAIL rmid_first_result: got v=%b id=%0d want v=1 id=0", out_valid, out_id);
    end
    step(g);
    req_valid = '0;
    void'(sbq.pop_front());
    step(g);
  endtask

  task automatic test_carry_edge();
    int g;
    out_ready = 1'b1; req_valid = 4'b0001;
    req_a[15:0] = 16'h8000; req_b[15:0] = 16'h8000;
    #1;
    step(g);
    req_a[15:0] = 16'h7FFF; req_b[15:0] = 16'h0000;
    void'(sbq.pop_front());
    n_checks++;
    if ({out_valid, out_id, out_cout, out_sum} !== {1'b1, 2'd0, 1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL carry_8000: got v=%b id=%0d c=%b s=%h want v=1 id=0 c=1 s=0000", out_valid, out_id, out_cout, out_sum);
    end
    #1;
    step(g);
    req_valid = '0;
    void'(sbq.pop_front());
    n_checks++;
    if ({out_valid, out_id, out_cout, out_sum} !== {1'b1, 2'd0, 1'b0, 16'h7FFF}) begin
      n_fail++; $display("FAIL carry_7fff: got v=%b id=%0d c=%b s=%h want v=1 id=0 c=0 s=7fff", out_valid, out_id, out_cout, out_sum);
    end
    step(g);
    last_e = '0;
  endtask

  task automatic test_back_to_back();
    int g; exp_t e;
    int waits[NREQ] = '{0, 0, 0, 0};
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_a[i*W +: W] = 16'($urandom);
          req_b[i*W +: W] = 16'($urandom);
          waits[i] = 0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = model_pick(req_valid);
      n_checks++;
      if (req_ready !== ((g >= 0) ? 4'(1 << g) : 4'b0000)) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b want %b", c, req_ready, (g >= 0) ? 4'(1 << g) : 4'b0000);
      end
      step(g);
      if (g >= 0) begin
        n_checks++;
        if (waits[g] > NREQ - 1) begin
          n_fail++; $display("FAIL b2b_fairness[%0d]: got %0d other grants while waiting want <= %0d", c, waits[g], NREQ - 1);
        end
        for (int i = 0; i < NREQ; i++) if (i != g && req_valid[i]) waits[i]++;
        req_valid[g] = 1'b0;
        e = sbq.pop_front(); last_e = e;
        n_checks++;
        if (out_valid !== 1'b1 || {out_id, out_cout, out_sum} !== e) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: got v=%b id=%0d c=%b s=%h want v=1 id=%0d c=%b s=%h", c, out_valid, out_id, out_cout, out_sum, e.id, e.cout, e.sum);
        end
      end else begin
        n_checks++;
        if (out_valid !== m_ov || (m_ov && {out_id, out_cout, out_sum} !== last_e)) begin
          n_fail++; $display("FAIL b2b_idle[%0d]: got v=%b id=%0d s=%h want v=%b id=%0d s=%h", c, out_valid, out_id, out_sum, m_ov, last_e.id, last_e.sum);
        end
      end
    end
    req_valid = '0; out_ready = 1'b1;
    step(g);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; out_ready = 1'b0; req_a = '0; req_b = '0; last_e = '0;
    test_reset();
    test_single_add();
    test_all_valid();
    test_backpressure();
    test_wrap_skip();
    test_reset_mid();
    test_carry_edge();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpa_rr_arbiter.md
# cpa_rr_arbiter

Round-robin arbiter that shares one 16-bit prefix carry-propagate adder (`MG_CPA`) among `NREQ` independent requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester per cycle, feeds that requester's operands through the shared CPA, and registers the sum, carry-out and requester ID into a one-entry output stage with its own valid/ready handshake. It sits between multiplier/accumulator front-ends and the final-addition resource, so the adder area is spent once rather than per requester.

## Interface
- `NREQ`, default 4: number of requesters; must be at least 2.
- `WIDTH`, default 16: operand width; fixed to the CPA width.
- `IDW`, default 2: ID width; equals ceil(log2(`NREQ`)).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NREQ`  bit i is high when requester i has operands pending.
- `req_ready`  out  `NREQ`  one-hot grant; bit i high means requester i's operands are consumed this cycle.
- `req_a`  in  `NREQ*WIDTH`  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  `NREQ*WIDTH`  operand B; same packing as `req_a`.
- `out_valid`  out  1  output register holds a result.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  `WIDTH`  registered sum, `(a+b) mod 2^WIDTH`.
- `out_cout`  out  1  registered carry-out of the addition.
- `out_id`  out  `IDW`  index of the requester that produced the result.

## Operation
- **Round-robin pointer.** Register `ptr`, width `IDW`, reset value 0. Search order is `ptr`, `ptr+1`, …, wrapping modulo `NREQ`. The first index with `req_valid` high is the candidate.
- **Accept condition.** `accept = !out_valid || out_ready`, i.e. the output register is empty or is being drained this cycle.
- **Grant.** `req_ready` is one-hot at the candidate when `accept` is high and any `req_valid` bit is high; otherwise `req_ready` is all zeros. `req_ready` never asserts for a requester whose `req_valid` is low.
- **Pointer update.** On a grant to index g, `ptr <= (g+1) mod NREQ`. With no grant, `ptr` holds.
- **Datapath.** A mux selects the granted requester's operands into the single CPA instance. Its sum and cout are captured into `out_sum`/`out_cout`, and g is captured into `out_id`. No carry-in: the operation is a pure a+b.
- **Output register load.**
  - Grant occurs: `out_valid <= 1`.
  - Drain (`out_valid && out_ready`) with no grant: `out_valid <= 0`.
  - Drain and grant in the same cycle: the register is reloaded and `out_valid` stays 1. The drained result is not duplicated and no bubble is inserted.
- **Output stability.** While `out_valid && !out_ready`, `out_sum`, `out_cout` and `out_id` hold.
- **Requester contract.** A requester keeps `req_a`/`req_b` stable and `req_valid` high until it sees `req_ready`. The arbiter samples operands only in the grant cycle.
- **Fairness.** A continuously valid requester is granted within `NREQ` consecutive grants.
- **Reset values.** `out_valid`=0, `out_sum`=0, `out_cout`=0, `out_id`=0, `ptr`=0. `req_ready` is all zeros during reset.
- **Reset mid-operation.** A pending, undrained result is discarded. No grant occurs in a cycle where `rst` is high.

## Timing
- **Latency.** A grant in cycle N gives `out_valid` high in cycle N+1 with that result.
- **Throughput.** One result per cycle while `out_ready` stays high.
- **Combinational paths.** `req_ready` depends combinationally on `req_valid`, `ptr`, `out_valid` and `out_ready`. The path `out_ready` → `req_ready` is permitted.
- **Registered outputs.** `out_*` are register outputs with no combinational input-to-output path. The CPA plus mux is the single register-to-register critical path.
- **Backpressure.** `out_ready` low for K cycles while `out_valid`=1 gives zero grants for those K cycles.

## Test plan
- **Single add.** `req_valid`=0001, `req_a[0]`=0xFFFF, `req_b[0]`=0x0001, `out_ready`=1 → `req_ready`=0001 in cycle 0. Cycle 1: `out_valid`=1, `out_sum`=0x0000, `out_cout`=1, `out_id`=0.
- **All requesters valid.** All four continuously valid, operands a=i·0x1111, b=0x0100, `out_ready`=1 → grants in order 0,1,2,3,0,…
  - `out_id` sequence 0,1,2,3,0.
  - `out_sum` for id 2 is 0x2322, cout 0.
  - One result every cycle, no bubbles.
- **Backpressure.** Requesters 1 and 3 valid, `out_ready`=0 for 5 cycles after the first result → `out_*` frozen and `req_ready`=0000 for those 5 cycles. `out_ready` rising then causes the drain and the next grant (id 3) in the same cycle, and `out_valid` stays 1.
- **Pointer wrap and skip.** `ptr`=3 (after granting 2), only requester 1 valid → grant 1, then `ptr`=2. Requester 1 alone again → granted again next cycle.
- **Reset mid-operation.** `out_valid`=1 holding id 2 and `out_ready`=0, then assert `rst` for 1 cycle → next cycle `out_valid`=0, `out_sum`=0, `ptr`=0. With requesters 0 and 2 valid afterwards, requester 0 is granted first.
- **Carry-out edge.** a=0x8000, b=0x8000 → sum 0x0000, cout 1. a=0x7FFF, b=0x0000 → sum 0x7FFF, cout 0.
